// File: rtl/serial_byte_loader_if.sv
// Serial byte loader bus: serial input side plus assembled-byte output side.
interface serial_byte_loader_if;
  logic       start;
  logic       clr;
  logic       sin;
  logic       sin_valid;
  logic [7:0] data_out;
  logic       load;
  logic       busy;
  logic       err;

  modport master (
    output start, clr, sin, sin_valid,
    input  data_out, load, busy, err
  );

  modport slave (
    input  start, clr, sin, sin_valid,
    output data_out, load, busy, err
  );
endinterface

// File: rtl/serial_byte_loader.sv
// Assembles 8 serial bits into a byte and strobes load for one cycle.
// Optional even-parity 9th bit enabled by defining PARITY_CHECK_EN.
module serial_byte_loader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_byte_loader_if.slave   bus
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, LOAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd3} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       load_q, load_d;
`ifdef PARITY_CHECK_EN
  logic       err_q, err_d;
`endif

  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    if (LSB_FIRST) shift_in = {b, cur[7:1]};
    else           shift_in = {cur[6:0], b};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
`ifdef PARITY_CHECK_EN
    err_d   = err_q;
`endif
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SHIFT;
            cnt_d   = 3'd0;
            shreg_d = 8'h00;
`ifdef PARITY_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (bus.sin_valid) begin
            shreg_d = shift_in(shreg_q, bus.sin);
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
              state_d = PARITY;
`else
              state_d = LOAD;
              data_d  = shreg_d;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        // Even parity: the parity bit equals the XOR of the data bits.
        PARITY: begin
          if (bus.sin_valid) begin
            if (bus.sin == ^shreg_q) begin
              state_d = LOAD;
              data_d  = shreg_q;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
`endif
        LOAD:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // load is registered: it rises on the edge that enters LOAD.
    load_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      load_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      load_q  <= load_d;
`ifdef PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.data_out = data_q;
  assign bus.load     = load_q;
  assign bus.busy     = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_byte_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   loads_a = 0;
  int   loads_b = 0;

  serial_byte_loader_if ifa ();
  serial_byte_loader_if ifb ();

  assign ifb.start     = ifa.start;
  assign ifb.clr       = ifa.clr;
  assign ifb.sin       = ifa.sin;
  assign ifb.sin_valid = ifa.sin_valid;

  serial_byte_loader #(.LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(ifa.slave));
  serial_byte_loader #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.load) loads_a++;
    if (ifb.load) loads_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ifa.sin       = b;
    ifa.sin_valid = 1'b1;
    tick();
    ifa.sin_valid = 1'b0;
  endtask

  // Start pulse with a simultaneous valid bit that must be ignored.
  task automatic do_start();
    ifa.start     = 1'b1;
    ifa.sin       = 1'b1;
    ifa.sin_valid = 1'b1;
    tick();
    ifa.start     = 1'b0;
    ifa.sin_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
`ifdef PARITY_CHECK_EN
    send_bit(^v);
`endif
  endtask

  task automatic test_reset();
    ifa.start = 1'b0; ifa.clr = 1'b0; ifa.sin = 1'b0; ifa.sin_valid = 1'b0;
    #12;
    checks++; if (ifa.data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", ifa.data_out); end
    checks++; if (ifa.load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", ifa.load); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifa.busy); end
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ifa.err); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    loads_a = 0;
    do_start();
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got %b exp 1", ifa.busy); end
    send_byte(8'hA5);
    checks++; if (ifa.load !== 1'b1) begin errors++; $display("FAIL basic_load got %b exp 1", ifa.load); end
    checks++; if (ifa.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_lsb got %h exp a5", ifa.data_out); end
    checks++; if (ifb.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_msb got %h exp a5", ifb.data_out); end
    checks++; if (ifb.load !== 1'b1) begin errors++; $display("FAIL basic_load_msb got %b exp 1", ifb.load); end
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", ifa.err); end
    tick();
    checks++; if (ifa.load !== 1'b0) begin errors++; $display("FAIL basic_load_drop got %b exp 0", ifa.load); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", ifa.busy); end
    checks++; if (ifa.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_hold got %h exp a5", ifa.data_out); end
    checks++; if (loads_a !== 1) begin errors++; $display("FAIL basic_load_count got %0d exp 1", loads_a); end
  endtask

  task automatic test_bit_order();
    do_start();
    send_byte(8'h07);
    checks++; if (ifa.data_out !== 8'h07) begin errors++; $display("FAIL order_lsb got %h exp 07", ifa.data_out); end
    checks++; if (ifb.data_out !== 8'hE0) begin errors++; $display("FAIL order_msb got %h exp e0", ifb.data_out); end
    tick();
  endtask

  task automatic test_gap_and_busy_start();
    logic [7:0] v;
    v = 8'hA5;
    loads_a = 0;
    do_start();
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    ifa.sin   = 1'b1;
    ifa.start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ifa.start = 1'b0;
    checks++; if (ifa.data_out !== 8'h07) begin errors++; $display("FAIL gap_data_hold got %h exp 07", ifa.data_out); end
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL gap_busy got %b exp 1", ifa.busy); end
    for (int i = 4; i < 8; i++) send_bit(v[i]);
`ifdef PARITY_CHECK_EN
    send_bit(^v);
`endif
    checks++; if (ifa.load !== 1'b1) begin errors++; $display("FAIL gap_load got %b exp 1", ifa.load); end
    checks++; if (ifa.data_out !== 8'hA5) begin errors++; $display("FAIL gap_data got %h exp a5", ifa.data_out); end
    tick(); tick();
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL gap_busy_idle got %b exp 0", ifa.busy); end
    checks++; if (loads_a !== 1) begin errors++; $display("FAIL gap_load_count got %0d exp 1", loads_a); end
  endtask

  task automatic test_clr();
    logic [7:0] v;
    v = 8'h3C;
    loads_a = 0;
    do_start();
    for (int i = 0; i < 5; i++) send_bit(v[i]);
    ifa.clr = 1'b1;
    ifa.sin_valid = 1'b1;
    tick();
    ifa.clr = 1'b0;
    ifa.sin_valid = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", ifa.busy); end
    checks++; if (ifa.data_out !== 8'hA5) begin errors++; $display("FAIL clr_data_kept got %h exp a5", ifa.data_out); end
    do_start();
    send_byte(v);
    checks++; if (ifa.load !== 1'b1) begin errors++; $display("FAIL clr_reload got %b exp 1", ifa.load); end
    checks++; if (ifa.data_out !== 8'h3C) begin errors++; $display("FAIL clr_data got %h exp 3c", ifa.data_out); end
    tick();
    checks++; if (loads_a !== 1) begin errors++; $display("FAIL clr_load_count got %0d exp 1", loads_a); end
  endtask

  task automatic test_async_reset();
    do_start();
    send_byte(8'h5A);
    tick();
    checks++; if (ifa.data_out !== 8'h5A) begin errors++; $display("FAIL arst_pre_data got %h exp 5a", ifa.data_out); end
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (ifa.data_out !== 8'h00) begin errors++; $display("FAIL arst_data got %h exp 00", ifa.data_out); end
    checks++; if (ifb.data_out !== 8'h00) begin errors++; $display("FAIL arst_data_msb got %h exp 00", ifb.data_out); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", ifa.busy); end
    checks++; if (ifa.load !== 1'b0) begin errors++; $display("FAIL arst_load got %b exp 0", ifa.load); end
    @(negedge clk);
    #2 rst = 1'b1;
    loads_a = 0;
    ifa.sin = 1'b1;
    ifa.sin_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    ifa.sin_valid = 1'b0;
    checks++; if (loads_a !== 0) begin errors++; $display("FAIL arst_no_load got %0d exp 0", loads_a); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL arst_busy_after got %b exp 0", ifa.busy); end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    logic [7:0] v;
    v = 8'h07;
    do_start();
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    checks++; if (ifa.load !== 1'b0) begin errors++; $display("FAIL par_wait_load got %b exp 0", ifa.load); end
    send_bit(1'b1);
    checks++; if (ifa.load !== 1'b1) begin errors++; $display("FAIL par_ok_load got %b exp 1", ifa.load); end
    checks++; if (ifa.data_out !== 8'h07) begin errors++; $display("FAIL par_ok_data got %h exp 07", ifa.data_out); end
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL par_ok_err got %b exp 0", ifa.err); end
    tick();
    do_start();
    send_byte(8'h3C);
    tick();
    loads_a = 0;
    do_start();
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(1'b0);
    checks++; if (ifa.err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b exp 1", ifa.err); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL par_bad_busy got %b exp 0", ifa.busy); end
    checks++; if (ifa.data_out !== 8'h3C) begin errors++; $display("FAIL par_bad_data got %h exp 3c", ifa.data_out); end
    tick(); tick();
    checks++; if (ifa.err !== 1'b1) begin errors++; $display("FAIL par_err_hold got %b exp 1", ifa.err); end
    checks++; if (loads_a !== 0) begin errors++; $display("FAIL par_bad_load got %0d exp 0", loads_a); end
    do_start();
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL par_err_clear got %b exp 0", ifa.err); end
    ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bit_order();
    test_gap_and_busy_start();
    test_clr();
    test_async_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_loader.md
SERIAL_BYTE_LOADER -- requirements
Module: serial_byte_loader

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = first accepted bit lands in data_out[0]; 0 = first bit lands in data_out[7].
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  begin assembling a byte; sampled only in IDLE.
REQ-005 clr  input  1  synchronous abort; returns to IDLE without loading.
REQ-006 sin  input  1  serial data bit.
REQ-007 sin_valid  input  1  sin is valid this cycle.
REQ-008 data_out  output  8  last successfully assembled byte; feeds the downstream 8-bit latch register D bus.
REQ-009 load  output  1  one-cycle strobe; data_out is new and valid this cycle; drives the latch-register enable.
REQ-010 busy  output  1  1 in any state other than IDLE.
REQ-011 err  output  1  parity error flag; constant 0 when PARITY_CHECK_EN is undefined.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY (present only with PARITY_CHECK_EN), and LOAD.
REQ-013 In IDLE, start=1 SHALL move the FSM to SHIFT, clear the shift register and the 3-bit bit counter, and clear err.
REQ-014 A sin_valid asserted in the same cycle as the accepted start SHALL be ignored; the first bit is accepted no earlier than the next cycle.
REQ-015 In SHIFT, each cycle with sin_valid=1 SHALL shift sin in per LSB_FIRST and increment the counter; cycles with sin_valid=0 SHALL hold state.
REQ-016 When the 8th bit is accepted (counter=7 and sin_valid=1), the FSM SHALL go to PARITY if PARITY_CHECK_EN is defined, otherwise to LOAD; data_out SHALL take the assembled byte on that same edge.
REQ-017 In LOAD, load SHALL be 1 for exactly one cycle; the FSM then returns to IDLE unconditionally.
REQ-018 Latency: load SHALL be asserted in the cycle immediately after the edge that accepts the final bit (the 8th data bit, or the parity bit).
REQ-019 load SHALL be a registered output that is never asserted outside LOAD.
REQ-020 data_out SHALL hold its value between loads and SHALL change only on the edge entering LOAD.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 clr=1 SHALL return the FSM to IDLE on the next edge from any state; no load is issued; data_out is retained; clr has priority over start and sin_valid.
REQ-023 If clr=1 in LOAD, load SHALL still complete its current cycle, because load is registered.

Reset
REQ-024 While rst=0, the block SHALL force the following values asynchronously: state=IDLE, counter=0, shift register=8'h00, data_out=8'h00, load=0, busy=0, err=0.
REQ-025 A reset asserted mid-byte SHALL discard the partial byte; after rst returns to 1, no load occurs until a new start is accepted.

Configuration
REQ-026 Macro PARITY_CHECK_EN: when defined, a 9th serial bit (even parity over the 8 data bits) SHALL be accepted in PARITY on sin_valid=1.
REQ-027 With PARITY_CHECK_EN defined and parity correct, the FSM SHALL go to LOAD and data_out SHALL update on that edge; on parity mismatch, the FSM SHALL go to IDLE, set err=1, issue no load, and leave data_out unchanged.
REQ-028 With PARITY_CHECK_EN defined, err SHALL hold until the next accepted start or reset.
REQ-029 Without PARITY_CHECK_EN, the PARITY state and parity logic SHALL be absent, err SHALL be tied to 0, and REQ-016 SHALL go directly to LOAD.

Verification
REQ-030 LSB_FIRST=1, start, then bits 1,0,1,0,0,1,0,1 on consecutive valid cycles -> data_out=8'hA5 with load=1 exactly one cycle after the 8th bit; busy=0 the following cycle.
REQ-031 LSB_FIRST=0, same bit stream -> data_out=8'hA5 reversed, i.e. 8'hA5 read MSB-first.
REQ-032 Same stream as REQ-030 with sin_valid gapped low for 3 cycles between bits 4 and 5 -> data_out=8'hA5; load latency measured from the 8th bit is unchanged.
REQ-033 clr after 5 bits, then a full byte 8'h3C -> no load for the aborted byte; a single load with data_out=8'h3C.
REQ-034 rst=0 asynchronously (between clock edges) mid-byte after an earlier load of 8'h5A -> all outputs zero immediately, including data_out=8'h00; no load after release.
REQ-035 PARITY_CHECK_EN defined: byte 8'h07 with parity bit 1 -> load with data_out=8'h07 and err=0; byte 8'h07 with parity bit 0 -> err=1, no load, data_out unchanged.
